// File: rtl/activation_interp.sv
// rtl/activation_interp.sv - three-stage piecewise-linear activation interpolator
// LUT address from S0, slope capture in S1, multiply/shift/saturate into the output register in S2.
module activation_interp #(
    parameter int IN_W   = 12,
    parameter int ADDR_W = 4,
    parameter int FRAC_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_base,
    input  logic [DATA_W-1:0] lut_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    localparam int PROD_W = DATA_W + FRAC_W + 2;
    localparam logic [ADDR_W-1:0] POS_END = ADDR_W'((1 << (ADDR_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(1 << (DATA_W - 1)));

    logic                     v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [FRAC_W-1:0]        frac0_q, frac0_d, frac1_q, frac1_d;
    logic signed [DATA_W-1:0] base_q, base_d;
    logic signed [DATA_W:0]   diff_q, diff_d;
    logic [DATA_W-1:0]        out_q, out_d;

    logic                     advance;
    logic signed [DATA_W:0]   diff_raw;
    logic signed [PROD_W-1:0] prod, sum;
    logic [DATA_W-1:0]        sat;

    always_comb begin
        advance  = !v2_q || out_ready;
        diff_raw = {lut_next[DATA_W-1], lut_next} - {lut_base[DATA_W-1], lut_base};

        prod = $signed(PROD_W'(diff_q)) * $signed(PROD_W'({1'b0, frac1_q}));
        sum  = $signed(PROD_W'(base_q)) + (prod >>> FRAC_W);
        if (sum > SAT_MAX) begin
            sat = SAT_MAX[DATA_W-1:0];
        end else if (sum < SAT_MIN) begin
            sat = SAT_MIN[DATA_W-1:0];
        end else begin
            sat = sum[DATA_W-1:0];
        end

        v0_d    = v0_q;
        addr_d  = addr_q;
        frac0_d = frac0_q;
        v1_d    = v1_q;
        base_d  = base_q;
        diff_d  = diff_q;
        frac1_d = frac1_q;
        v2_d    = v2_q;
        out_d   = out_q;

        if (advance) begin
            v0_d    = in_valid;
            addr_d  = in_data[IN_W-1 -: ADDR_W];
            frac0_d = in_data[FRAC_W-1:0];
            v1_d    = v0_q;
            base_d  = $signed(lut_base);
            // Top positive segment would otherwise slope toward the most negative entry.
            diff_d  = (addr_q == POS_END) ? '0 : diff_raw;
            frac1_d = frac0_q;
            v2_d    = v1_q;
            out_d   = sat;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v0_q    <= 1'b0;
            addr_q  <= '0;
            frac0_q <= '0;
            v1_q    <= 1'b0;
            base_q  <= '0;
            diff_q  <= '0;
            frac1_q <= '0;
            v2_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            v0_q    <= v0_d;
            addr_q  <= addr_d;
            frac0_q <= frac0_d;
            v1_q    <= v1_d;
            base_q  <= base_d;
            diff_q  <= diff_d;
            frac1_q <= frac1_d;
            v2_q    <= v2_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = advance;
    assign lut_addr  = addr_q;
    assign out_valid = v2_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_activation_interp.sv
// tb/tb_activation_interp.sv - self-checking bench for activation_interp
// Combinational LUT model plus an arithmetic reference of the interpolation rule.
module tb_activation_interp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic [3:0]  lut_addr;
    logic [7:0]  lut_base, lut_next;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    int lut_tab [16] = '{0, 12, 15, -100, 127, -128, 60, 15,
                         -15, -90, -128, 127, 40, -60, -30, -12};

    logic       s_ov, s_ir;
    logic [7:0] s_od;
    logic [3:0] s_la;

    activation_interp dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .lut_addr(lut_addr), .lut_base(lut_base), .lut_next(lut_next),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    assign lut_base = 8'(lut_tab[lut_addr]);
    assign lut_next = 8'(lut_tab[4'(lut_addr + 4'd1)]);

    function automatic int ref_act(input logic [11:0] x);
        int a, f, b, n, d, p, q, s;
        a = int'(x[11:8]);
        f = int'(x[7:0]);
        b = lut_tab[a];
        n = lut_tab[(a + 1) % 16];
        d = (a == 7) ? 0 : n - b;
        p = d * f;
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        s = b + q;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic do_cycle(input logic iv, input logic [11:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
        s_ov = out_valid;
        s_od = out_data;
        s_ir = in_ready;
        s_la = lut_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || lut_addr !== 4'd0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b data=%0d addr=%0d required 0/0/0", out_valid, out_data, lut_addr);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_mapping();
        logic [11:0] vals [4];
        int          want [4];
        vals = '{12'h000, 12'h080, 12'h200, 12'h800};
        want = '{0, 6, 15, -15};
        for (int c = 0; c < 10; c++) begin
            do_cycle(c < 4, (c < 4) ? vals[c] : 12'h000, 1'b1);
            n_cmp++;
            if (s_ov !== (c >= 3 && c <= 6)) begin
                n_err++;
                $display("FAIL mapping_valid: cycle %0d out_valid=%b required %b", c, s_ov, (c >= 3 && c <= 6));
            end else if (s_ov && s_od !== 8'(want[c-3])) begin
                n_err++;
                $display("FAIL mapping_data: cycle %0d got %0d required %0d", c, $signed(s_od), want[c-3]);
            end
        end
    endtask

    task automatic test_edges();
        logic [11:0] vals [3];
        int          want [3];
        vals = '{12'h7FF, 12'hF80, 12'h180};
        want = '{15, -6, 13};
        for (int c = 0; c < 8; c++) begin
            do_cycle(c < 3, (c < 3) ? vals[c] : 12'h000, 1'b1);
            if (c >= 3 && c <= 5) begin
                n_cmp++;
                if (s_ov !== 1'b1 || s_od !== 8'(want[c-3])) begin
                    n_err++;
                    $display("FAIL edge_%0h: valid=%b got %0d required %0d", vals[c-3], s_ov, $signed(s_od), want[c-3]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] items [8];
        logic        pat [8];
        int          k, got, e;
        logic        prev_stall, ordy;
        logic [7:0]  prev_od;
        logic [3:0]  prev_la;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) items[i] = 12'($urandom);
        k = 0; got = 0; prev_stall = 1'b0; prev_od = '0; prev_la = '0;
        for (int c = 0; c < 80 && got < 8; c++) begin
            ordy = pat[c % 8];
            do_cycle(k < 8, (k < 8) ? items[k] : 12'h000, ordy);
            n_cmp++;
            if (s_ir !== (!s_ov || ordy)) begin
                n_err++;
                $display("FAIL bp_in_ready: cycle %0d in_ready=%b required %b", c, s_ir, (!s_ov || ordy));
            end
            if (prev_stall) begin
                n_cmp++;
                if (s_od !== prev_od || s_la !== prev_la) begin
                    n_err++;
                    $display("FAIL bp_stable: cycle %0d data=%0d addr=%0d required %0d/%0d", c, s_od, s_la, prev_od, prev_la);
                end
            end
            if (s_ov && ordy) begin
                n_cmp++;
                got++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra: unexpected result %0d", $signed(s_od));
                end else begin
                    e = exp_q.pop_front();
                    if (s_od !== 8'(e)) begin
                        n_err++;
                        $display("FAIL bp_data: got %0d required %0d", $signed(s_od), e);
                    end
                end
            end
            if (k < 8 && s_ir) begin
                exp_q.push_back(ref_act(items[k]));
                k++;
            end
            prev_stall = s_ov && !ordy;
            prev_od = s_od;
            prev_la = s_la;
        end
        n_cmp++;
        if (got != 8 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_count: received %0d required 8 (pending %0d)", got, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [11:0] x;
        for (int c = 0; c < 3; c++) do_cycle(1'b1, 12'($urandom), 1'b1);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_inflight: out_valid=%b required 1", out_valid);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || lut_addr !== 4'd0) begin
            n_err++;
            $display("FAIL rst_mid_async: valid=%b data=%0d addr=%0d required 0/0/0", out_valid, out_data, lut_addr);
        end
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        x = 12'($urandom);
        for (int c = 0; c < 8; c++) begin
            do_cycle(c == 2, x, 1'b1);
            n_cmp++;
            if (s_ov !== (c == 5)) begin
                n_err++;
                $display("FAIL rst_mid_valid: cycle %0d out_valid=%b required %b", c, s_ov, (c == 5));
            end else if (s_ov && s_od !== 8'(ref_act(x))) begin
                n_err++;
                $display("FAIL rst_mid_data: got %0d required %0d", $signed(s_od), ref_act(x));
            end
        end
    endtask

    task automatic test_bubbles();
        logic [11:0] items [10];
        logic        want_v;
        for (int i = 0; i < 10; i++) items[i] = 12'($urandom);
        for (int c = 0; c < 15; c++) begin
            do_cycle(c < 10 && (c % 2 == 0), (c < 10) ? items[c] : 12'h000, 1'b1);
            want_v = (c >= 3 && c < 13 && ((c - 3) % 2 == 0));
            n_cmp++;
            if (s_ov !== want_v) begin
                n_err++;
                $display("FAIL bubble_valid: cycle %0d out_valid=%b required %b", c, s_ov, want_v);
            end else if (want_v && s_od !== 8'(ref_act(items[c-3]))) begin
                n_err++;
                $display("FAIL bubble_data: cycle %0d got %0d required %0d", c, $signed(s_od), ref_act(items[c-3]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        iv, ordy;
        logic [11:0] x;
        int          e;
        for (int c = 0; c < 260; c++) begin
            iv   = (c < 240) ? ($urandom_range(0, 3) != 0) : 1'b0;
            ordy = (c < 240) ? ($urandom_range(0, 3) != 0) : 1'b1;
            x    = 12'($urandom);
            do_cycle(iv, x, ordy);
            n_cmp++;
            if (s_ir !== (!s_ov || ordy)) begin
                n_err++;
                $display("FAIL b2b_in_ready: cycle %0d in_ready=%b required %b", c, s_ir, (!s_ov || ordy));
            end
            if (s_ov && ordy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra: unexpected result %0d", $signed(s_od));
                end else begin
                    e = exp_q.pop_front();
                    if (s_od !== 8'(e)) begin
                        n_err++;
                        $display("FAIL b2b_data: cycle %0d got %0d required %0d", c, $signed(s_od), e);
                    end
                end
            end
            if (iv && s_ir) exp_q.push_back(ref_act(x));
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_drain: %0d results missing, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_edges();
        test_backpressure();
        test_reset_mid();
        test_bubbles();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
